wrr_scheduler: RTL and testbench

- Per-egress-port weighted round-robin scheduler for the packet switch crossbar; one instance per egress port, drop-in successor to the plain round-robin egress scheduler.
- Grants one ingress at a time at packet granularity. Each grant allows up to weight[i] whole packets back-to-back before the pointer advances.
- Weights are runtime-configurable per ingress; weight 0 disables that ingress for this egress.

---
 rtl/switch_pkg.sv | 27 ++
 rtl/rr_pick.sv | 33 +++
 rtl/wrr_scheduler.sv | 150 +++++++++++++++
 tb/tb_wrr_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | switch_pkg: shared constants, scheduler states and helpers            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package switch_pkg;

  localparam int N_PORTS        = 4;
  localparam int IDX_WIDTH      = 2;
  localparam int WEIGHT_WIDTH   = 4;
  localparam int DEFAULT_WEIGHT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  function automatic logic [N_PORTS-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [N_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick: rotating-priority search, first request at or after i_rr_ptr |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_rr_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = i_rr_ptr + W'(i);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wrr_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wrr_scheduler: per-egress weighted round-robin packet scheduler       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module wrr_scheduler #(
  parameter int N_PORTS        = switch_pkg::N_PORTS,
  parameter int IDX_WIDTH      = switch_pkg::IDX_WIDTH,
  parameter int WEIGHT_WIDTH   = switch_pkg::WEIGHT_WIDTH,
  parameter int DEFAULT_WEIGHT = switch_pkg::DEFAULT_WEIGHT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_PORTS-1:0]             ingress_valid,
  input  logic [N_PORTS-1:0]             ingress_last,
  input  logic [N_PORTS*IDX_WIDTH-1:0]   ingress_dst,
  input  logic [IDX_WIDTH-1:0]           egress_port_id,
  input  logic                           egress_ready,
  input  logic                           cfg_we,
  input  logic [IDX_WIDTH-1:0]           cfg_idx,
  input  logic [WEIGHT_WIDTH-1:0]        cfg_weight,
  output logic [IDX_WIDTH-1:0]           selected_ingress,
  output logic                           egress_valid,
  output logic                           egress_last,
  output logic [N_PORTS-1:0]             grant,
  output logic [N_PORTS-1:0]             ingress_ready,
  output logic                           pkt_done
);

  import switch_pkg::*;

  logic [WEIGHT_WIDTH-1:0] r_weight [N_PORTS];
  sched_state_t            r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_WIDTH-1:0]    r_select, w_select_nxt;
  logic [WEIGHT_WIDTH-1:0] r_credit, w_credit_nxt;
  logic [N_PORTS-1:0]      r_grant, w_grant_nxt;
  logic [N_PORTS-1:0]      w_req;
  logic                    w_found;
  logic [IDX_WIDTH-1:0]    w_pick;
  logic                    w_last_hs;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_req
      assign w_req[gi] = ingress_valid[gi]
                      && (ingress_dst[gi*IDX_WIDTH +: IDX_WIDTH] == egress_port_id)
                      && (r_weight[gi] != '0);
    end
  endgenerate

  rr_pick #(
    .N (N_PORTS),
    .W (IDX_WIDTH)
  ) u_pick (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  always_comb begin
    egress_valid  = 1'b0;
    egress_last   = 1'b0;
    ingress_ready = '0;
    if (r_state == SEND) begin
      egress_valid            = ingress_valid[r_select];
      egress_last             = ingress_last[r_select];
      ingress_ready[r_select] = egress_ready;
    end
  end

  assign w_last_hs        = (r_state == SEND) && ingress_valid[r_select]
                         && ingress_last[r_select] && egress_ready;
  assign pkt_done         = w_last_hs;
  assign selected_ingress = r_select;
  assign grant            = r_grant;

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_select_nxt = r_select;
    w_credit_nxt = r_credit;
    w_grant_nxt  = r_grant;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_select_nxt = w_pick;
          w_credit_nxt = r_weight[w_pick];
          w_grant_nxt  = onehot(w_pick);
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        if (w_last_hs) begin
          w_credit_nxt = r_credit - WEIGHT_WIDTH'(1);
          if (r_credit == WEIGHT_WIDTH'(1)) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_select + IDX_WIDTH'(1);
            w_grant_nxt  = '0;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_req[r_select]) begin
          w_state_nxt = SEND;
        end else begin
          // Leftover credit is forfeited when the holder has nothing queued.
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = r_select + IDX_WIDTH'(1);
          w_grant_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_select <= '0;
      r_credit <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_select <= w_select_nxt;
      r_credit <= w_credit_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  // A same-cycle credit load sees the pre-write weight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_weight[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end
    end else if (cfg_we) begin
      r_weight[cfg_idx] <= cfg_weight;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wrr_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_wrr_scheduler: directed self-checking bench for wrr_scheduler      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_wrr_scheduler;

  logic       clk;
  logic       reset_n;
  logic [3:0] ingress_valid;
  logic [3:0] ingress_last;
  logic [7:0] ingress_dst;
  logic [1:0] egress_port_id;
  logic       egress_ready;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_weight;
  logic [1:0] selected_ingress;
  logic       egress_valid;
  logic       egress_last;
  logic [3:0] grant;
  logic [3:0] ingress_ready;
  logic       pkt_done;

  wrr_scheduler u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ingress_valid    (ingress_valid),
    .ingress_last     (ingress_last),
    .ingress_dst      (ingress_dst),
    .egress_port_id   (egress_port_id),
    .egress_ready     (egress_ready),
    .cfg_we           (cfg_we),
    .cfg_idx          (cfg_idx),
    .cfg_weight       (cfg_weight),
    .selected_ingress (selected_ingress),
    .egress_valid     (egress_valid),
    .egress_last      (egress_last),
    .grant            (grant),
    .ingress_ready    (ingress_ready),
    .pkt_done         (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Packet sources: remaining packets, packet length, current beat, dst, gate.
  int         pkts [4];
  int         len  [4];
  int         beat [4];
  logic [1:0] dstv [4];
  bit         gate [4];
  bit         toggle;

  int cycle;
  int n_done, oh_bad, mirror_bad, eg_beats, n_last_hs, first_hs;
  int n_beats [4];
  int n_pkts  [4];
  int done_q [$];
  int done_t [$];

  int exp1 [6]  = '{0, 1, 2, 0, 1, 2};
  int exp2 [12] = '{0, 1, 2, 2, 2, 3, 0, 1, 2, 2, 2, 3};
  int exp3 [3]  = '{2, 3, 0};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      ingress_valid[i]       = (pkts[i] > 0) && !gate[i];
      ingress_last[i]        = (beat[i] == len[i] - 1);
      ingress_dst[i*2 +: 2]  = dstv[i];
    end
  endtask

  task automatic clear_stats();
    n_done = 0; oh_bad = 0; mirror_bad = 0; eg_beats = 0; n_last_hs = 0; first_hs = -1;
    for (int i = 0; i < 4; i++) begin
      n_beats[i] = 0;
      n_pkts[i]  = 0;
    end
    done_q.delete();
    done_t.delete();
  endtask

  task automatic cyc();
    logic [3:0] hs;
    @(negedge clk);
    cycle++;
    hs = ingress_valid & ingress_ready;
    if (pkt_done) n_done++;
    if (grant != 4'd0 && !$onehot(grant)) oh_bad++;
    if (egress_valid && egress_ready) eg_beats++;
    if (egress_valid && egress_ready && egress_last) n_last_hs++;
    if (egress_valid && (egress_last !== ingress_last[selected_ingress])) mirror_bad++;
    for (int i = 0; i < 4; i++) begin
      if (ingress_ready[i] && !(grant[i] && (int'(selected_ingress) == i) && egress_ready))
        mirror_bad++;
      if (hs[i]) begin
        if (first_hs < 0) first_hs = cycle;
        n_beats[i]++;
        if (ingress_last[i]) begin
          done_q.push_back(i);
          done_t.push_back(cycle);
          n_pkts[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkts[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    if (toggle) egress_ready = ~egress_ready;
    drive();
  endtask

  task automatic src(input int i, input int n, input int l, input logic [1:0] d);
    pkts[i] = n; len[i] = l; beat[i] = 0; dstv[i] = d; gate[i] = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) src(i, 0, 1, 2'd0);
    cfg_we = 1'b0; egress_ready = 1'b1; toggle = 1'b0;
    reset_n = 1'b0;
    drive();
    cyc();
    cyc();
    reset_n = 1'b1;
    clear_stats();
  endtask

  task automatic cfg(input int idx, input int w);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_weight = 4'(w);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (done_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, int'(done_q.size() >= n), 1);
  endtask

  initial begin
    int s;
    cycle = 0; reset_n = 1'b0; egress_port_id = 2'd0; egress_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_weight = 4'd0; toggle = 1'b0;
    ingress_valid = '0; ingress_last = '0; ingress_dst = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_sel", selected_ingress, 0);
    chk("rst_evalid", egress_valid, 0);
    chk("rst_pkt_done", pkt_done, 0);
    @(posedge clk); #1;

    // Plain round robin, 3-beat packets toward egress 1
    egress_port_id = 2'd1;
    do_reset();
    src(0, 2, 3, 2'd1); src(1, 2, 3, 2'd1); src(2, 2, 3, 2'd1);
    drive();
    s = cycle;
    run_until(6, 200, "t1_timeout");
    for (int k = 0; k < 6; k++) chk($sformatf("t1_order%0d", k), done_q[k], exp1[k]);
    chk("t1_pkt_done_cnt", n_done, 6);
    chk("t1_onehot", oh_bad, 0);
    chk("t1_first_beat_lat", first_hs - s, 2);

    // Weighted round robin, weight[2]=3, 1-beat packets toward egress 0
    egress_port_id = 2'd0;
    do_reset();
    cfg(2, 3);
    for (int i = 0; i < 4; i++) src(i, 1000, 1, 2'd0);
    drive();
    run_until(12, 200, "t2_timeout");
    for (int k = 0; k < 12; k++) chk($sformatf("t2_order%0d", k), done_q[k], exp2[k]);
    chk("t2_gap_0_1", done_t[1] - done_t[0], 2);
    chk("t2_gap_2_2a", done_t[3] - done_t[2], 2);
    chk("t2_gap_2_2b", done_t[4] - done_t[3], 2);

    // Credit forfeit: ingress 2 has one packet, pointer then moves to 3
    do_reset();
    cfg(2, 3);
    src(2, 1, 1, 2'd0); src(0, 1, 1, 2'd0); src(3, 1, 1, 2'd0);
    gate[0] = 1'b1; gate[3] = 1'b1;
    drive();
    run_until(1, 50, "t3_timeout_a");
    gate[0] = 1'b0; gate[3] = 1'b0;
    drive();
    run_until(3, 50, "t3_timeout_b");
    for (int k = 0; k < 3; k++) chk($sformatf("t3_order%0d", k), done_q[k], exp3[k]);
    chk("t3_gap_2_3", done_t[1] - done_t[0], 3);

    // Toggling egress_ready through a 4-beat packet
    do_reset();
    toggle = 1'b1;
    src(1, 1, 4, 2'd0);
    drive();
    run_until(1, 50, "t4_timeout");
    for (int k = 0; k < 3; k++) cyc();
    chk("t4_src_beats", n_beats[1], 4);
    chk("t4_egress_beats", eg_beats, 4);
    chk("t4_last_hs", n_last_hs, 1);
    chk("t4_ready_mirror", mirror_bad, 0);
    toggle = 1'b0; egress_ready = 1'b1;

    // Weight 0 written mid-packet: packet finishes, ingress then excluded
    do_reset();
    cfg(1, 2);
    src(1, 3, 4, 2'd0); src(2, 3, 1, 2'd0);
    drive();
    for (int k = 0; k < 20 && n_beats[1] < 1; k++) cyc();
    cfg(1, 0);
    run_until(4, 100, "t5_timeout_a");
    for (int k = 0; k < 10; k++) cyc();
    chk("t5_first_pkt", done_q[0], 1);
    chk("t5_pkts_in1", n_pkts[1], 1);
    chk("t5_pkts_in2", n_pkts[2], 3);
    cfg(1, 1);
    run_until(6, 100, "t5_timeout_b");
    chk("t5_pkts_in1_after", n_pkts[1], 3);

    // Reset mid-packet
    do_reset();
    cfg(1, 0);
    src(1, 1, 4, 2'd0); src(3, 1, 4, 2'd0);
    drive();
    for (int k = 0; k < 30 && n_beats[3] < 2; k++) cyc();
    chk("t6_mid_pkt", n_beats[3], 2);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_grant", grant, 0);
    chk("t6_evalid", egress_valid, 0);
    chk("t6_sel", selected_ingress, 0);
    @(posedge clk); #1;
    clear_stats();
    run_until(1, 50, "t6_timeout");
    chk("t6_first_after_rst", done_q[0], 1);
    chk("t6_onehot", oh_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
